idex_hazard: RTL and testbench
==============================

IDEX_HAZARD -- requirements
Module: idex_hazard

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, the width of the stall statistics counter.
REQ-002 The block SHALL have port clk_i  input  1  system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_i  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port Flush_i  input  1  branch-taken flush; kills the instruction now in ID.
REQ-005 The block SHALL have port PC_i  input  32  PC+4 of the ID instruction, from the IF/ID register.
REQ-006 The block SHALL have port instruction_i  input  32  ID instruction, from the IF/ID register.
REQ-007 The block SHALL have ports RSdata_i, RTdata_i, SignExt_i  input  32 each  register-file read data and sign-extended immediate.
REQ-008 The block SHALL have ports RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, ALUSrc_i, RegDst_i  input  1 each, and ALUOp_i  input  2  decoded control.
REQ-009 The block SHALL have registered outputs PC_o, RSdata_o, RTdata_o, SignExt_o (32 each), RS_o, RT_o, RD_o (5 each: instruction bits 25:21, 20:16, 15:11), funct_o (6: bits 5:0), and the control signals with suffix _o.
REQ-010 The block SHALL have port valid_o  output  1  EX-stage slot holds a real instruction.
REQ-011 The block SHALL have port Stall_o  output  1  combinational; holds PC and the IF/ID register this cycle.
REQ-012 The block SHALL have port stall_cnt_o  output  CNT_W  count of load-use stall cycles.

Function
REQ-013 Load-use hazard SHALL be: valid_o AND MemRead_o AND RT_o != 0 AND (RT_o == instruction_i[25:21] OR RT_o == instruction_i[20:16]).
REQ-014 Stall_o SHALL equal hazard AND NOT Flush_i, evaluated combinationally in the same cycle.
REQ-015 Normal cycle (no hazard, no flush): all inputs SHALL be captured into the corresponding outputs at the next edge; valid_o <= 1; latency one cycle.
REQ-016 Bubble cycle (hazard or Flush_i): RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, ALUSrc_o, RegDst_o, ALUOp_o and valid_o SHALL be cleared to 0; data and register-index outputs SHALL hold previous values.
REQ-017 Flush_i SHALL take priority over hazard: bubble inserted, Stall_o = 0, stall_cnt_o unchanged.
REQ-018 A load-use stall SHALL last exactly one cycle: the bubble clears valid_o, so hazard is false next cycle and the held instruction then advances.
REQ-019 stall_cnt_o SHALL increment by 1 on every edge where Stall_o = 1 and saturate at all-ones (no wrap).
REQ-020 An all-zero instruction_i (NOP) SHALL never raise a hazard (RT_o != 0 rule, rs/rt fields 0).

Reset
REQ-021 Asserting rst_i SHALL immediately, without a clock edge, clear every registered output, valid_o and stall_cnt_o to 0; Stall_o is thus 0 during reset.
REQ-022 Reset asserted mid-stall SHALL discard the bubble/hold state; the first edge after deassertion is a normal capture.

Configuration
REQ-023 With macro IDEX_LOADUSE_EN defined, hazard detection, Stall_o and stall_cnt_o SHALL behave per REQ-013..REQ-019.
REQ-024 Without IDEX_LOADUSE_EN, hazard SHALL be constant 0, Stall_o tied 0, stall_cnt_o tied 0; Flush_i bubbles and normal capture unchanged.

Verification
REQ-025 Reset: rst_i=1 with nonzero inputs, no clock -> all outputs 0 immediately; release, one edge with RegWrite_i=1, PC_i=32'h8 -> RegWrite_o=1, PC_o=8, valid_o=1.
REQ-026 Load-use: capture lw with rt=5 (MemRead_i=1), next instruction_i rs=5 -> Stall_o=1 that cycle, next edge valid_o=0 and controls 0, stall_cnt_o=1; following cycle Stall_o=0 and instruction captured.
REQ-027 Flush priority: same hazard setup with Flush_i=1 -> Stall_o=0, bubble inserted, stall_cnt_o unchanged.
REQ-028 No false hazard: lw with rt=0 followed by rs=0, and lw rt=5 followed by rs=6/rt=7 -> Stall_o=0 both cases.
REQ-029 Saturation: CNT_W=2, force 5 consecutive load-use pairs -> stall_cnt_o reads 1,2,3,3,3.
REQ-030 Build without IDEX_LOADUSE_EN, repeat REQ-026 stimulus -> Stall_o=0, dependent instruction captured next edge, stall_cnt_o=0.

Source files
------------

// File: rtl/idex_hazard.sv
// ID/EX pipeline register with load-use hazard detection and stall counter.
// Optional feature macro: IDEX_LOADUSE_EN enables hazard detection, Stall_o
// and stall_cnt_o; without it they are tied to 0 and only Flush_i bubbles.
// Ports:
//   clk_i, rst_i (async active-high), Flush_i
//   PC_i, instruction_i, RSdata_i, RTdata_i, SignExt_i : ID-stage data
//   RegWrite_i..RegDst_i, ALUOp_i                      : ID-stage control
//   *_o                                                : registered EX copies
//   valid_o     : EX slot holds a real instruction
//   Stall_o     : combinational, holds PC and IF/ID this cycle
//   stall_cnt_o : saturating count of load-use stall cycles
module idex_hazard #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             Flush_i,
  input  logic [31:0]      PC_i,
  input  logic [31:0]      instruction_i,
  input  logic [31:0]      RSdata_i,
  input  logic [31:0]      RTdata_i,
  input  logic [31:0]      SignExt_i,
  input  logic             RegWrite_i,
  input  logic             MemtoReg_i,
  input  logic             MemRead_i,
  input  logic             MemWrite_i,
  input  logic             ALUSrc_i,
  input  logic             RegDst_i,
  input  logic [1:0]       ALUOp_i,
  output logic [31:0]      PC_o,
  output logic [31:0]      RSdata_o,
  output logic [31:0]      RTdata_o,
  output logic [31:0]      SignExt_o,
  output logic [4:0]       RS_o,
  output logic [4:0]       RT_o,
  output logic [4:0]       RD_o,
  output logic [5:0]       funct_o,
  output logic             RegWrite_o,
  output logic             MemtoReg_o,
  output logic             MemRead_o,
  output logic             MemWrite_o,
  output logic             ALUSrc_o,
  output logic             RegDst_o,
  output logic [1:0]       ALUOp_o,
  output logic             valid_o,
  output logic             Stall_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  logic [31:0] pc_q, rsd_q, rtd_q, sext_q;
  logic [31:0] pc_d, rsd_d, rtd_d, sext_d;
  logic [4:0]  rs_q, rt_q, rd_q;
  logic [4:0]  rs_d, rt_d, rd_d;
  logic [5:0]  funct_q, funct_d;
  logic [7:0]  ctrl_q, ctrl_d;
  logic        valid_q, valid_d;
  logic        hazard;
  logic        stall;
  logic        bubble;

`ifdef IDEX_LOADUSE_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // rt_q != 0 keeps loads to x0 and all-zero NOPs from stalling
  assign hazard = valid_q & ctrl_q[5] & (rt_q != 5'd0) &
                  ((rt_q == instruction_i[25:21]) |
                   (rt_q == instruction_i[20:16]));

  always_comb begin
    cnt_d = cnt_q;
    if (stall && !(&cnt_q)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign stall_cnt_o = cnt_q;
`else
  assign hazard      = 1'b0;
  assign stall_cnt_o = '0;
`endif

  // Flush wins: the killed instruction must not also stall the front end
  assign stall  = hazard & ~Flush_i;
  assign bubble = hazard | Flush_i;

  always_comb begin
    pc_d    = pc_q;
    rsd_d   = rsd_q;
    rtd_d   = rtd_q;
    sext_d  = sext_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    rd_d    = rd_q;
    funct_d = funct_q;
    ctrl_d  = 8'd0;
    valid_d = 1'b0;
    if (!bubble) begin
      pc_d    = PC_i;
      rsd_d   = RSdata_i;
      rtd_d   = RTdata_i;
      sext_d  = SignExt_i;
      rs_d    = instruction_i[25:21];
      rt_d    = instruction_i[20:16];
      rd_d    = instruction_i[15:11];
      funct_d = instruction_i[5:0];
      ctrl_d  = {RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i,
                 ALUSrc_i, RegDst_i, ALUOp_i};
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q    <= '0;
      rsd_q   <= '0;
      rtd_q   <= '0;
      sext_q  <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      rd_q    <= '0;
      funct_q <= '0;
      ctrl_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      rsd_q   <= rsd_d;
      rtd_q   <= rtd_d;
      sext_q  <= sext_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      rd_q    <= rd_d;
      funct_q <= funct_d;
      ctrl_q  <= ctrl_d;
      valid_q <= valid_d;
    end
  end

  assign PC_o       = pc_q;
  assign RSdata_o   = rsd_q;
  assign RTdata_o   = rtd_q;
  assign SignExt_o  = sext_q;
  assign RS_o       = rs_q;
  assign RT_o       = rt_q;
  assign RD_o       = rd_q;
  assign funct_o    = funct_q;
  assign RegWrite_o = ctrl_q[7];
  assign MemtoReg_o = ctrl_q[6];
  assign MemRead_o  = ctrl_q[5];
  assign MemWrite_o = ctrl_q[4];
  assign ALUSrc_o   = ctrl_q[3];
  assign RegDst_o   = ctrl_q[2];
  assign ALUOp_o    = ctrl_q[1:0];
  assign valid_o    = valid_q;
  assign Stall_o    = stall;

endmodule

// File: tb/tb_idex_hazard.sv
// Directed bench for idex_hazard; expectations follow the build's
// IDEX_LOADUSE_EN setting. A second instance with CNT_W=2 shows saturation.
module tb_idex_hazard;

`ifdef IDEX_LOADUSE_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        Flush_i;
  logic [31:0] PC_i, instruction_i, RSdata_i, RTdata_i, SignExt_i;
  logic        RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i;
  logic        ALUSrc_i, RegDst_i;
  logic [1:0]  ALUOp_i;

  logic [31:0] PC_o, RSdata_o, RTdata_o, SignExt_o;
  logic [4:0]  RS_o, RT_o, RD_o;
  logic [5:0]  funct_o;
  logic        RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o;
  logic        ALUSrc_o, RegDst_o, valid_o, Stall_o;
  logic [1:0]  ALUOp_o;
  logic [15:0] stall_cnt_o;

  logic [31:0] b_PC, b_RSd, b_RTd, b_SExt;
  logic [4:0]  b_RS, b_RT, b_RD;
  logic [5:0]  b_funct;
  logic        b_RW, b_M2R, b_MR, b_MW, b_AS, b_RDst, b_valid, b_stall;
  logic [1:0]  b_ALUOp;
  logic [1:0]  b_cnt;

  int vectors = 0;
  int errors  = 0;

  localparam logic [31:0] LW5  = {6'h23, 5'd1, 5'd5, 16'h0004};
  localparam logic [31:0] LW0  = {6'h23, 5'd1, 5'd0, 16'h0008};
  localparam logic [31:0] ADD5 = {6'h00, 5'd5, 5'd2, 5'd3, 5'd0, 6'h20};
  localparam logic [31:0] ADD0 = {6'h00, 5'd0, 5'd0, 5'd4, 5'd0, 6'h20};
  localparam logic [31:0] ADD6 = {6'h00, 5'd6, 5'd7, 5'd8, 5'd0, 6'h20};

  always #5 clk = ~clk;

  idex_hazard dut (
    .clk_i(clk), .rst_i(rst), .Flush_i(Flush_i), .PC_i(PC_i),
    .instruction_i(instruction_i), .RSdata_i(RSdata_i),
    .RTdata_i(RTdata_i), .SignExt_i(SignExt_i),
    .RegWrite_i(RegWrite_i), .MemtoReg_i(MemtoReg_i),
    .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
    .ALUSrc_i(ALUSrc_i), .RegDst_i(RegDst_i), .ALUOp_i(ALUOp_i),
    .PC_o(PC_o), .RSdata_o(RSdata_o), .RTdata_o(RTdata_o),
    .SignExt_o(SignExt_o), .RS_o(RS_o), .RT_o(RT_o), .RD_o(RD_o),
    .funct_o(funct_o), .RegWrite_o(RegWrite_o),
    .MemtoReg_o(MemtoReg_o), .MemRead_o(MemRead_o),
    .MemWrite_o(MemWrite_o), .ALUSrc_o(ALUSrc_o),
    .RegDst_o(RegDst_o), .ALUOp_o(ALUOp_o), .valid_o(valid_o),
    .Stall_o(Stall_o), .stall_cnt_o(stall_cnt_o)
  );

  idex_hazard #(.CNT_W(2)) dut2 (
    .clk_i(clk), .rst_i(rst), .Flush_i(Flush_i), .PC_i(PC_i),
    .instruction_i(instruction_i), .RSdata_i(RSdata_i),
    .RTdata_i(RTdata_i), .SignExt_i(SignExt_i),
    .RegWrite_i(RegWrite_i), .MemtoReg_i(MemtoReg_i),
    .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
    .ALUSrc_i(ALUSrc_i), .RegDst_i(RegDst_i), .ALUOp_i(ALUOp_i),
    .PC_o(b_PC), .RSdata_o(b_RSd), .RTdata_o(b_RTd),
    .SignExt_o(b_SExt), .RS_o(b_RS), .RT_o(b_RT), .RD_o(b_RD),
    .funct_o(b_funct), .RegWrite_o(b_RW), .MemtoReg_o(b_M2R),
    .MemRead_o(b_MR), .MemWrite_o(b_MW), .ALUSrc_o(b_AS),
    .RegDst_o(b_RDst), .ALUOp_o(b_ALUOp), .valid_o(b_valid),
    .Stall_o(b_stall), .stall_cnt_o(b_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] pc,
                       input logic mr, input logic rw, input logic rd,
                       input logic [1:0] op);
    instruction_i = ins;
    PC_i          = pc;
    MemRead_i     = mr;
    MemtoReg_i    = mr;
    ALUSrc_i      = mr;
    RegWrite_i    = rw;
    RegDst_i      = rd;
    ALUOp_i       = op;
  endtask

  initial begin
    rst = 1'b1;
    Flush_i = 1'b0;
    RSdata_i = 32'h1111_2222;
    RTdata_i = 32'h3333_4444;
    SignExt_i = 32'hFFFF_FFF0;
    MemWrite_i = 1'b0;
    drive(ADD5, 32'h44, 1'b1, 1'b1, 1'b1, 2'd3);
    #2;
    rst = 1'b0;
    step();
    // mid-cycle async reset with nonzero state and inputs
    rst = 1'b1;
    #1;
    check("rst_pc", PC_o, 32'h0);
    check("rst_rsdata", RSdata_o, 32'h0);
    check("rst_rs", {27'd0, RS_o}, 32'h0);
    check("rst_regwrite", {31'd0, RegWrite_o}, 32'h0);
    check("rst_aluop", {30'd0, ALUOp_o}, 32'h0);
    check("rst_valid", {31'd0, valid_o}, 32'h0);
    check("rst_cnt", {16'd0, stall_cnt_o}, 32'h0);
    check("rst_stall", {31'd0, Stall_o}, 32'h0);
    rst = 1'b0;

    drive(32'h0, 32'h8, 1'b0, 1'b1, 1'b0, 2'd0);
    step();
    check("cap_regwrite", {31'd0, RegWrite_o}, 32'h1);
    check("cap_pc", PC_o, 32'h8);
    check("cap_valid", {31'd0, valid_o}, 32'h1);

    // load-use: lw rt=5 then add rs=5
    drive(LW5, 32'hC, 1'b1, 1'b1, 1'b0, 2'd0);
    step();
    check("lw_rt", {27'd0, RT_o}, 32'd5);
    check("lw_memread", {31'd0, MemRead_o}, 32'h1);
    drive(ADD5, 32'h10, 1'b0, 1'b1, 1'b1, 2'd2);
    #1;
    check("lu_stall", {31'd0, Stall_o}, {31'd0, EN});
    step();
    check("lu_valid", {31'd0, valid_o}, {31'd0, !EN});
    check("lu_regwrite", {31'd0, RegWrite_o}, {31'd0, !EN});
    check("lu_cnt", {16'd0, stall_cnt_o}, {31'd0, EN});
    check("lu_rs_hold", {27'd0, RS_o}, EN ? 32'd1 : 32'd5);
    check("lu_stall_gone", {31'd0, Stall_o}, 32'h0);
    step();
    check("lu_adv_valid", {31'd0, valid_o}, 32'h1);
    check("lu_adv_rs", {27'd0, RS_o}, 32'd5);
    check("lu_adv_rd", {27'd0, RD_o}, 32'd3);
    check("lu_adv_aluop", {30'd0, ALUOp_o}, 32'd2);
    check("lu_adv_pc", PC_o, 32'h10);

    // flush over hazard
    drive(LW5, 32'h14, 1'b1, 1'b1, 1'b0, 2'd0);
    step();
    drive(ADD5, 32'h18, 1'b0, 1'b1, 1'b1, 2'd2);
    Flush_i = 1'b1;
    #1;
    check("fl_stall", {31'd0, Stall_o}, 32'h0);
    step();
    Flush_i = 1'b0;
    check("fl_valid", {31'd0, valid_o}, 32'h0);
    check("fl_memread", {31'd0, MemRead_o}, 32'h0);
    check("fl_cnt", {16'd0, stall_cnt_o}, {31'd0, EN});
    check("fl_pc_hold", PC_o, 32'h14);

    // no false hazards
    drive(LW0, 32'h20, 1'b1, 1'b1, 1'b0, 2'd0);
    step();
    drive(ADD0, 32'h24, 1'b0, 1'b1, 1'b1, 2'd2);
    #1;
    check("nf_rt0", {31'd0, Stall_o}, 32'h0);
    drive(LW5, 32'h28, 1'b1, 1'b1, 1'b0, 2'd0);
    step();
    drive(ADD6, 32'h2C, 1'b0, 1'b1, 1'b1, 2'd2);
    #1;
    check("nf_rs6rt7", {31'd0, Stall_o}, 32'h0);
    drive(32'h0, 32'h2C, 1'b0, 1'b0, 1'b0, 2'd0);
    #1;
    check("nf_nop", {31'd0, Stall_o}, 32'h0);

    // reset in the middle of a stall
    drive(ADD5, 32'h30, 1'b0, 1'b1, 1'b1, 2'd2);
    #1;
    check("rs_stall_pre", {31'd0, Stall_o}, {31'd0, EN});
    rst = 1'b1;
    #1;
    check("rs_stall", {31'd0, Stall_o}, 32'h0);
    check("rs_valid", {31'd0, valid_o}, 32'h0);
    check("rs_cnt", {16'd0, stall_cnt_o}, 32'h0);
    rst = 1'b0;
    step();
    check("rs_cap_valid", {31'd0, valid_o}, 32'h1);
    check("rs_cap_rs", {27'd0, RS_o}, 32'd5);

    // saturation on the 2-bit counter
    for (int i = 0; i < 5; i++) begin
      drive(LW5, 32'h40, 1'b1, 1'b1, 1'b0, 2'd0);
      step();
      drive(ADD5, 32'h44, 1'b0, 1'b1, 1'b1, 2'd2);
      step();
      check($sformatf("sat_%0d", i), {30'd0, b_cnt},
            EN ? ((i < 3) ? i + 1 : 3) : 0);
      step();
    end
    check("sat_wide_cnt", {16'd0, stall_cnt_o}, EN ? 32'd5 : 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
